// File: rtl/dual_rail_rx_pkg.sv
// Shared types and constants for the dual-rail result-channel receiver.
package dual_rail_rx_pkg;

  // Handshake phase of the 4-phase dual-rail protocol as seen by the receiver.
  typedef enum logic [0:0] {
    WAIT_DATA   = 1'b0,
    WAIT_SPACER = 1'b1
  } rx_state_e;

  localparam int unsigned DR_W_DEF   = 32;
  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/dr_sync2.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
module dr_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage shift register; the first stage may go metastable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/dual_rail_rx.sv
// Clocked receiver for a 4-phase dual-rail channel: synchronised completion and
// spacer detection, 2-entry capture FIFO, sticky illegal-codeword flag and a
// received-word counter.
module dual_rail_rx
  import dual_rail_rx_pkg::*;
#(
  parameter int W     = DR_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [W-1:0]     a_0r0,
  input  logic [W-1:0]     a_0r1,
  output logic             a_0a,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] rx_count
);

  // A bit with both rails high is not a legal dual-rail code.
  function automatic logic both_rails_high(input logic [W-1:0] r0, input logic [W-1:0] r1);
    return |(r0 & r1);
  endfunction

  logic       complete_raw_s;
  logic       spacer_raw_s;
  logic       complete_s;
  logic       spacer_s;
  rx_state_e  state_r;
  rx_state_e  state_nxt_s;
  logic       push_s;
  logic       pop_s;
  logic       ack_r;
  logic [W-1:0] head_r;
  logic [W-1:0] tail_r;
  logic [W-1:0] head_nxt_s;
  logic [W-1:0] tail_nxt_s;
  logic [1:0] count_r;
  logic [1:0] count_nxt_s;
  logic       valid_r;
  logic       full_r;
  logic       err_r;
  logic [CNT_W-1:0] cnt_r;

  assign complete_raw_s = &(a_0r0 | a_0r1);
  assign spacer_raw_s   = ~|(a_0r0 | a_0r1);

  dr_sync2 u_sync_complete (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (complete_raw_s),
    .q       (complete_s)
  );

  dr_sync2 u_sync_spacer (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (spacer_raw_s),
    .q       (spacer_s)
  );

  // Handshake FSM: capture on completion when there is room, release on spacer.
  always_comb begin
    state_nxt_s = state_r;
    push_s      = 1'b0;
    case (state_r)
      WAIT_DATA: begin
        if (complete_s && !full_r) begin
          push_s      = 1'b1;
          state_nxt_s = WAIT_SPACER;
        end else begin
          state_nxt_s = WAIT_DATA;
        end
      end
      WAIT_SPACER: begin
        if (spacer_s) begin
          state_nxt_s = WAIT_DATA;
        end else begin
          state_nxt_s = WAIT_SPACER;
        end
      end
      default: begin
        state_nxt_s = WAIT_DATA;
      end
    endcase
  end

  // State register; ack is high exactly while waiting for the spacer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= WAIT_DATA;
      ack_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ack_r   <= (state_nxt_s == WAIT_SPACER);
    end
  end

  assign pop_s = valid_r & out_ready;

  // FIFO next state: head_r is always the oldest word so out_data stays registered.
  always_comb begin
    head_nxt_s  = head_r;
    tail_nxt_s  = tail_r;
    count_nxt_s = count_r;
    case (count_r)
      2'd0: begin
        if (push_s) begin
          head_nxt_s  = a_0r1;
          count_nxt_s = 2'd1;
        end else begin
          count_nxt_s = 2'd0;
        end
      end
      2'd1: begin
        if (push_s && pop_s) begin
          head_nxt_s  = a_0r1;
          count_nxt_s = 2'd1;
        end else if (push_s) begin
          tail_nxt_s  = a_0r1;
          count_nxt_s = 2'd2;
        end else if (pop_s) begin
          count_nxt_s = 2'd0;
        end else begin
          count_nxt_s = 2'd1;
        end
      end
      2'd2: begin
        if (pop_s) begin
          head_nxt_s  = tail_r;
          count_nxt_s = 2'd1;
        end else begin
          count_nxt_s = 2'd2;
        end
      end
      default: begin
        count_nxt_s = 2'd0;
      end
    endcase
  end

  // FIFO storage plus registered valid/full flags derived from the next count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_r  <= {W{1'b0}};
      tail_r  <= {W{1'b0}};
      count_r <= 2'd0;
      valid_r <= 1'b0;
      full_r  <= 1'b0;
    end else begin
      head_r  <= head_nxt_s;
      tail_r  <= tail_nxt_s;
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != 2'd0);
      full_r  <= (count_nxt_s == 2'(FIFO_DEPTH));
    end
  end

  // Sticky error flag; a new error wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= (err_r & ~err_clr) | (push_s & both_rails_high(a_0r0, a_0r1));
    end
  end

  // Received-word counter, wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (push_s) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign a_0a      = ack_r;
  assign out_data  = head_r;
  assign out_valid = valid_r;
  assign err       = err_r;
  assign rx_count  = cnt_r;

endmodule

// File: tb/tb_dual_rail_rx.sv
// Self-checking bench for dual_rail_rx: scoreboard of expected words checked at
// the output stream, plus per-scenario inline checks of handshake timing and flags.
module tb_dual_rail_rx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] a_0r0;
  logic [31:0] a_0r1;
  logic        a_0a;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        err;
  logic        err_clr;
  logic [15:0] rx_count;

  int          n_vec = 0;
  int          n_err = 0;
  int          exp_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  bit          stream_done;

  dual_rail_rx #(.W(32), .CNT_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a_0r0     (a_0r0),
    .a_0r1     (a_0r1),
    .a_0a      (a_0a),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .err_clr   (err_clr),
    .rx_count  (rx_count)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every accepted output word must match the oldest expected one.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got %h, expected nothing pending", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp) begin
          n_err++;
          $display("FAIL sb_data: got %h, expected %h", out_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_word(input logic [31:0] d, input logic [31:0] both);
    a_0r1 = d | both;
    a_0r0 = ~d | both;
  endtask

  task automatic drive_spacer();
    a_0r1 = 32'h0;
    a_0r0 = 32'h0;
  endtask

  // Wait (bounded) until a_0a reaches lvl; cyc returns edges consumed.
  task automatic wait_ack(input logic lvl, input int max_cyc, output int cyc);
    cyc = 0;
    while (cyc < max_cyc && a_0a !== lvl) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Full 4-phase handshake of one word, expected to be captured.
  task automatic send_word(input logic [31:0] d, input logic [31:0] both, input int lim);
    int cyc;
    @(posedge clk);
    #1;
    drive_word(d, both);
    exp_q.push_back(d | both);
    exp_cnt++;
    wait_ack(1'b1, lim, cyc);
    n_vec++;
    if (a_0a !== 1'b1) begin
      n_err++;
      $display("FAIL send_ack_rise: a_0a=%b after %0d cycles, expected 1 (word %h)", a_0a, cyc, d);
    end
    drive_spacer();
    wait_ack(1'b0, lim, cyc);
    n_vec++;
    if (a_0a !== 1'b0) begin
      n_err++;
      $display("FAIL send_ack_fall: a_0a=%b after %0d cycles, expected 0", a_0a, cyc);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    drive_spacer();
    #12;
    n_vec++;
    if ({a_0a, out_valid, err} !== 3'b000 || out_data !== 32'h0 || rx_count !== 16'h0) begin
      n_err++;
      $display("FAIL reset_state: a_0a=%b valid=%b err=%b data=%h cnt=%0d, expected all zero",
               a_0a, out_valid, err, out_data, rx_count);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (a_0a !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL idle_spacer: a_0a=%b valid=%b, expected 0 0", a_0a, out_valid);
    end
  endtask

  task automatic test_single_word();
    int cyc;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    drive_word(32'h0000_0010, 32'h0);
    exp_q.push_back(32'h0000_0010);
    exp_cnt++;
    wait_ack(1'b1, 10, cyc);
    n_vec++;
    if (a_0a !== 1'b1 || cyc != 3) begin
      n_err++;
      $display("FAIL single_ack_latency: a_0a=%b after %0d edges, expected 1 after 3", a_0a, cyc);
    end
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 32'h0000_0010) begin
      n_err++;
      $display("FAIL single_out: valid=%b data=%h, expected 1 00000010", out_valid, out_data);
    end
    drive_spacer();
    @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_valid_pulse: valid=%b, expected 0", out_valid);
    end
    wait_ack(1'b0, 10, cyc);
    n_vec++;
    if (a_0a !== 1'b0 || cyc > 3) begin
      n_err++;
      $display("FAIL single_ack_fall: a_0a=%b after %0d more edges, expected 0 within 3", a_0a, cyc);
    end
    n_vec++;
    if (rx_count !== 16'd1) begin
      n_err++;
      $display("FAIL single_count: rx_count=%0d, expected 1", rx_count);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    out_ready = 1'b0;
    send_word(32'h1, 32'h0, 20);
    send_word(32'h2, 32'h0, 20);
    @(posedge clk);
    #1;
    drive_word(32'h3, 32'h0);
    exp_q.push_back(32'h3);
    exp_cnt++;
    wait_ack(1'b1, 12, cyc);
    n_vec++;
    if (a_0a !== 1'b0) begin
      n_err++;
      $display("FAIL bp_hold: a_0a=%b with FIFO full, expected 0", a_0a);
    end
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 32'h1) begin
      n_err++;
      $display("FAIL bp_head: valid=%b data=%h, expected 1 00000001", out_valid, out_data);
    end
    out_ready = 1'b1;
    wait_ack(1'b1, 10, cyc);
    n_vec++;
    if (a_0a !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: a_0a=%b after drain, expected 1", a_0a);
    end
    drive_spacer();
    wait_ack(1'b0, 10, cyc);
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0 || rx_count !== 16'(exp_cnt)) begin
      n_err++;
      $display("FAIL bp_drain: pending=%0d rx_count=%0d, expected 0 pending count %0d",
               exp_q.size(), rx_count, exp_cnt);
    end
  endtask

  task automatic test_illegal();
    int cyc;
    out_ready = 1'b1;
    send_word(32'h0000_0F00, 32'h0000_0020, 20);
    n_vec++;
    if (err !== 1'b1 || rx_count !== 16'(exp_cnt)) begin
      n_err++;
      $display("FAIL illegal_flag: err=%b rx_count=%0d, expected 1 and %0d", err, rx_count, exp_cnt);
    end
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    n_vec++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL illegal_clear: err=%b, expected 0", err);
    end
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    drive_word(32'h0000_0005, 32'h0000_0020);
    exp_q.push_back(32'h0000_0025);
    exp_cnt++;
    wait_ack(1'b1, 10, cyc);
    err_clr = 1'b0;
    n_vec++;
    if (err !== 1'b1 || a_0a !== 1'b1) begin
      n_err++;
      $display("FAIL illegal_clr_collide: err=%b a_0a=%b, expected 1 1", err, a_0a);
    end
    drive_spacer();
    wait_ack(1'b0, 10, cyc);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  task automatic test_partial();
    int cyc;
    bit seen;
    out_ready = 1'b1;
    seen = 1'b0;
    @(posedge clk);
    #1;
    a_0r1 = 32'h1234_5678 & 32'h7FFF_FFFF;
    a_0r0 = ~32'h1234_5678 & 32'h7FFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (a_0a === 1'b1 || out_valid === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (seen) begin
      n_err++;
      $display("FAIL partial_no_capture: ack/valid seen=%b, expected 0", seen);
    end
    a_0r0[31] = 1'b1;
    exp_q.push_back(32'h1234_5678);
    exp_cnt++;
    wait_ack(1'b1, 10, cyc);
    n_vec++;
    if (a_0a !== 1'b1 || cyc > 3) begin
      n_err++;
      $display("FAIL partial_complete: a_0a=%b after %0d edges, expected 1 within 3", a_0a, cyc);
    end
    drive_spacer();
    wait_ack(1'b0, 10, cyc);
  endtask

  task automatic test_reset_mid();
    int cyc;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    drive_word(32'hCAFE_0001, 32'h0);
    exp_q.push_back(32'hCAFE_0001);
    exp_cnt++;
    wait_ack(1'b1, 10, cyc);
    n_vec++;
    if (a_0a !== 1'b1 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mid_setup: a_0a=%b valid=%b, expected 1 1", a_0a, out_valid);
    end
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    #1;
    n_vec++;
    if (a_0a !== 1'b0 || out_valid !== 1'b0 || rx_count !== 16'd0) begin
      n_err++;
      $display("FAIL mid_reset: a_0a=%b valid=%b cnt=%0d, expected 0 0 0", a_0a, out_valid, rx_count);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.push_back(32'hCAFE_0001);
    exp_cnt++;
    wait_ack(1'b1, 10, cyc);
    n_vec++;
    if (a_0a !== 1'b1 || rx_count !== 16'd1) begin
      n_err++;
      $display("FAIL mid_recapture: a_0a=%b cnt=%0d, expected 1 1", a_0a, rx_count);
    end
    out_ready = 1'b1;
    drive_spacer();
    wait_ack(1'b0, 10, cyc);
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL mid_drain: pending=%0d, expected 0", exp_q.size());
    end
  endtask

  task automatic test_stream();
    int wait_cyc;
    do_reset();
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          send_word($urandom, 32'h0, 300);
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 20) begin
      @(posedge clk);
      #1;
      wait_cyc++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL stream_drain: pending=%0d, expected 0", exp_q.size());
    end
    n_vec++;
    if (rx_count !== 16'd100 || err !== 1'b0) begin
      n_err++;
      $display("FAIL stream_final: rx_count=%0d err=%b, expected 100 0", rx_count, err);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_illegal();
    test_partial();
    test_reset_mid();
    test_stream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
